uart_rx: RTL

//  UART receiver for 8N1 frames (1 start, 8 data LSB-first, 1 stop, no parity).

---
 rtl/uart_rx_pkg.sv | 21 ++
 rtl/uart_rx_sync.sv | 45 ++++
 rtl/uart_rx.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg: definitions shared by the UART receiver and its transmitter
// counterpart, so both ends agree on frame state names and on the bit period.
//   uart_state_e : frame-level state encoding (IDLE/START/DATA/STOP/BREAK)
//   uart_ticks() : clock cycles per line bit, CLOCK_HZ / BAUD (integer divide)
package uart_rx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_BREAK
    } uart_state_e;

    // Cycles per bit. The receiver needs at least 4 so that the half-bit
    // reload (ticks/2 - 1) is non-zero and a mid-bit sample point exists.
    function automatic int uart_ticks(input int clock_hz, input int baud);
        return clock_hz / baud;
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: two-flop synchroniser for the asynchronous serial line plus a
// falling-edge detector on the synchronised value.
//   Clock   in  system clock, rising edge
//   Reset   in  asynchronous, active-low reset
//   Rx_i    in  raw serial line, idle high
//   RxS_o   out synchronised line
//   Fall_o  out one-cycle strobe on a genuine 1->0 transition of RxS_o
module uart_rx_sync (
    input  logic Clock,
    input  logic Reset,
    input  logic Rx_i,
    output logic RxS_o,
    output logic Fall_o
);

    logic       meta_q;
    logic       rxs_q;
    logic       prev_q;
    logic [1:0] vld_q;

    // The synchroniser flops reset to 1 (idle line), but that value is not a
    // real observation. vld_q tracks when rxs_q holds a real line sample, and
    // prev_q stays 0 until then, so a line already low at reset exit never
    // looks like a start edge: an edge needs a real high followed by a low.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            // NOTE: state flops use non-blocking assignments so every flop
            // samples the pre-edge value of the others; blocking here would
            // collapse the two synchroniser stages into one.
            meta_q <= 1'b1;
            rxs_q  <= 1'b1;
            vld_q  <= 2'b00;
            prev_q <= 1'b0;
        end else begin
            meta_q <= Rx_i;
            rxs_q  <= meta_q;
            vld_q  <= {vld_q[0], 1'b1};
            prev_q <= vld_q[1] ? rxs_q : 1'b0;
        end
    end

    assign RxS_o  = rxs_q;
    assign Fall_o = prev_q & ~rxs_q;

endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver (1 start, 8 data LSB-first, 1 stop, no parity).
//   Clock         in   system clock, rising edge
//   Reset         in   asynchronous, active-low reset
//   Rx_i          in   serial line, idle high, asynchronous to Clock
//   Data_o        out  last correctly received byte, held until next good frame
//   Done_o        out  1-cycle pulse: Data_o updated with a good frame
//   FrameError_o  out  1-cycle pulse: stop bit sampled low, byte discarded
//   Busy_o        out  high while a frame is being received (incl. break wait)
// Parameters: CLOCK_HZ, BAUD; cycles per bit = CLOCK_HZ/BAUD, must be >= 4.
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int CLOCK_HZ = 1_000_000,
    parameter int BAUD     = 100_000
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       Rx_i,
    output logic [7:0] Data_o,
    output logic       Done_o,
    output logic       FrameError_o,
    output logic       Busy_o
);

    localparam int TICKS  = uart_ticks(CLOCK_HZ, BAUD);
    localparam int TICK_W = $clog2(TICKS);
    localparam logic [TICK_W-1:0] HALF_RELOAD = TICK_W'(TICKS / 2 - 1);
    localparam logic [TICK_W-1:0] FULL_RELOAD = TICK_W'(TICKS - 1);

    logic rxs;
    logic fall;

    uart_rx_sync u_sync (
        .Clock  (Clock),
        .Reset  (Reset),
        .Rx_i   (Rx_i),
        .RxS_o  (rxs),
        .Fall_o (fall)
    );

    uart_state_e       state_q, state_d;
    logic [TICK_W-1:0] cnt_q, cnt_d;
    logic [2:0]        bit_q, bit_d;
    logic [7:0]        shift_q, shift_d;
    logic [7:0]        data_q, data_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    // A sample point is reached when the tick counter has run down to zero.
    logic sample;
    assign sample = (cnt_q == '0);

    // State register
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        // NOTE: every combinational output gets a default before the case so
        // no path leaves it unassigned, which would otherwise infer a latch.
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (fall) state_d = ST_START;
            ST_START: if (sample) state_d = rxs ? ST_IDLE : ST_DATA;
            ST_DATA:  if (sample && bit_q == 3'd7) state_d = ST_STOP;
            ST_STOP:  if (sample) state_d = rxs ? ST_IDLE : ST_BREAK;
            ST_BREAK: if (rxs) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Output / datapath logic
    always_comb begin
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        data_d  = data_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        Busy_o  = (state_q != ST_IDLE);
        unique case (state_q)
            ST_IDLE: begin
                // Half-bit load puts subsequent samples in mid-bit.
                if (fall) begin
                    cnt_d = HALF_RELOAD;
                    bit_d = 3'd0;
                end
            end
            ST_START: begin
                if (sample) begin
                    cnt_d = FULL_RELOAD;
                    bit_d = 3'd0;
                end else begin
                    cnt_d = cnt_q - TICK_W'(1);
                end
            end
            ST_DATA: begin
                if (sample) begin
                    // LSB arrives first, so shifting in at the MSB leaves
                    // bit 0 in position 0 after the eighth sample.
                    shift_d = {rxs, shift_q[7:1]};
                    cnt_d   = FULL_RELOAD;
                    bit_d   = bit_q + 3'd1;
                end else begin
                    cnt_d = cnt_q - TICK_W'(1);
                end
            end
            ST_STOP: begin
                if (sample) begin
                    if (rxs) begin
                        data_d = shift_q;
                        done_d = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - TICK_W'(1);
                end
            end
            default: ;
        endcase
    end

    // Datapath registers
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            cnt_q   <= '0;
            bit_q   <= 3'd0;
            shift_q <= 8'h00;
            data_q  <= 8'h00;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign Data_o       = data_q;
    assign Done_o       = done_q;
    assign FrameError_o = err_q;

endmodule
